// File: rtl/hex_word_entry_pkg.sv
// hex_word_entry_pkg: shared types and constants for the hex word entry path.
package hex_word_entry_pkg;
    typedef enum logic {ENTRY, REQUEST} state_t;
    localparam int NIBBLE_W = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_NIBBLES = 8;
    localparam int ID_WIDTH = 5;
    localparam int WORD_W = NIBBLE_W * DEFAULT_NIBBLES;
endpackage

// File: rtl/hex_word_entry_if.sv
// hex_word_entry_if: valid/ready register-write request toward the debug port.
interface hex_word_entry_if import hex_word_entry_pkg::*; #(
    parameter int ID_W   = ID_WIDTH,
    parameter int DATA_W = WORD_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ID_W-1:0]   wr_id;
    logic [DATA_W-1:0] wr_data;
    modport master (output wr_valid, wr_id, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_id, wr_data, output wr_ready);
endinterface

// File: rtl/hex_word_entry_key_debouncer.sv
// key_debouncer: synchronizes and debounces an active-low button, emitting one pulse per press.
module key_debouncer import hex_word_entry_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_n,
    output logic press_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic          w_settled;
    assign w_settled   = (r_sync[1] != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press_pulse = r_pulse;
    // The pulse is raised on the same edge the level falls, so it lasts exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], raw_n};
            r_pulse <= w_settled && r_level;
            if (r_sync[1] == r_level || w_settled)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_settled)
                r_level <= r_sync[1];
        end
    end
endmodule

// File: rtl/hex_word_entry.sv
// hex_word_entry: assembles a hex word from debounced buttons and issues it as a register write.
module hex_word_entry import hex_word_entry_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NIBBLES         = DEFAULT_NIBBLES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        key_digit_n,
    input  logic                        key_commit_n,
    input  logic                        key_clear_n,
    input  logic [NIBBLE_W-1:0]         sw_nibble,
    input  logic [ID_WIDTH-1:0]         sw_reg_id,
    output logic [NIBBLE_W*NIBBLES-1:0] entry_word,
    output logic [3:0]                  digit_count,
    output logic                        busy,
    hex_word_entry_if.master            wr
);
    localparam int W = NIBBLE_W * NIBBLES;
    logic            w_digit, w_commit, w_clear;
    state_t          r_state, w_state;
    logic [W-1:0]    r_word, w_word, r_data, w_data;
    logic [3:0]      r_count, w_count;
    logic            r_valid, w_valid;
    logic [ID_WIDTH-1:0] r_id, w_id;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit (
        .clock(clock), .reset(reset), .raw_n(key_digit_n), .press_pulse(w_digit));
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
        .clock(clock), .reset(reset), .raw_n(key_commit_n), .press_pulse(w_commit));
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clock(clock), .reset(reset), .raw_n(key_clear_n), .press_pulse(w_clear));

    assign entry_word  = r_word;
    assign digit_count = r_count;
    assign busy        = r_state == REQUEST;
    assign wr.wr_valid = r_valid;
    assign wr.wr_id    = r_id;
    assign wr.wr_data  = r_data;

    // Presses arriving in REQUEST are dropped; only the transfer returns to ENTRY.
    always_comb begin
        w_state = r_state;
        w_word  = r_word;
        w_count = r_count;
        w_valid = r_valid;
        w_id    = r_id;
        w_data  = r_data;
        if (r_state == ENTRY) begin
            if (w_clear) begin
                w_word  = '0;
                w_count = '0;
            end else if (w_commit) begin
                if (r_count != '0) begin
                    w_id    = sw_reg_id;
                    w_data  = r_word;
                    w_valid = 1'b1;
                    w_state = REQUEST;
                end
            end else if (w_digit) begin
                w_word  = {r_word[W-NIBBLE_W-1:0], sw_nibble};
                w_count = (r_count == 4'(NIBBLES)) ? r_count : r_count + 4'd1;
            end
        end else if (r_valid && wr.wr_ready) begin
            w_valid = 1'b0;
            w_word  = '0;
            w_count = '0;
            w_state = ENTRY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ENTRY;
            r_word  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state;
            r_word  <= w_word;
            r_count <= w_count;
            r_valid <= w_valid;
            r_id    <= w_id;
            r_data  <= w_data;
        end
    end
endmodule

// File: tb/tb_hex_word_entry.sv
// tb_hex_word_entry: randomized and directed checks of hex_word_entry against a word-level model.
module tb_hex_word_entry;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_digit_n = 1'b1, key_commit_n = 1'b1, key_clear_n = 1'b1;
    logic [3:0]  sw_nibble = '0;
    logic [4:0]  sw_reg_id = '0;
    logic [31:0] entry_word;
    logic [3:0]  digit_count;
    logic        busy;
    int          checks = 0, failures = 0;
    logic [31:0] m_word = '0, m_data = '0;
    int          m_count = 0;
    logic        m_pending = 1'b0;
    logic [4:0]  m_id = '0;

    hex_word_entry_if wr_if ();

    hex_word_entry #(.DEBOUNCE_CYCLES(4), .NIBBLES(8)) dut (
        .clock(clock), .reset(reset),
        .key_digit_n(key_digit_n), .key_commit_n(key_commit_n), .key_clear_n(key_clear_n),
        .sw_nibble(sw_nibble), .sw_reg_id(sw_reg_id),
        .entry_word(entry_word), .digit_count(digit_count), .busy(busy),
        .wr(wr_if.master));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Word-level reference: what a single clean press of the given keys does.
    task automatic model_apply(input logic d, input logic c, input logic k);
        if (m_pending) return;
        if (k) begin
            m_word = '0;
            m_count = 0;
        end else if (c) begin
            if (m_count > 0) begin
                m_pending = 1'b1;
                m_id = sw_reg_id;
                m_data = m_word;
            end
        end else if (d) begin
            m_word = (m_word << 4) | 32'(sw_nibble);
            m_count = (m_count < 8) ? m_count + 1 : 8;
        end
    endtask

    task automatic press(input logic d, input logic c, input logic k);
        key_digit_n = ~d;
        key_commit_n = ~c;
        key_clear_n = ~k;
        repeat (10) tick();
        key_digit_n = 1'b1;
        key_commit_n = 1'b1;
        key_clear_n = 1'b1;
        repeat (10) tick();
        model_apply(d, c, k);
    endtask

    task automatic digit(input logic [3:0] n);
        sw_nibble = n;
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_if.wr_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({entry_word, digit_count, busy, wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data} !== 75'd0) begin
            failures++;
            $display("FAIL reset got=%h/%0d/%b/%b/%h/%h exp=all zero",
                     entry_word, digit_count, busy, wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data);
        end
    endtask

    task automatic test_debounce_timing();
        logic [3:0] bounce [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        sw_nibble = 4'hA;
        foreach (bounce[i]) begin
            key_digit_n = bounce[i][0];
            tick();
        end
        key_digit_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) begin
                checks++;
                if (entry_word !== 32'h0) begin
                    failures++;
                    $display("FAIL debounce_early got=%h exp=%h", entry_word, 32'h0);
                end
            end
        end
        checks++;
        if (entry_word !== 32'h0000000A || digit_count !== 4'd1) begin
            failures++;
            $display("FAIL debounce_latency got=%h/%0d exp=0000000a/1", entry_word, digit_count);
        end
        repeat (8) tick();
        key_digit_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (entry_word !== 32'h0000000A || digit_count !== 4'd1) begin
            failures++;
            $display("FAIL debounce_single_pulse got=%h/%0d exp=0000000a/1", entry_word, digit_count);
        end
        m_word = 32'hA;
        m_count = 1;
    endtask

    task automatic test_digit_saturation();
        press(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) digit(4'(i));
        checks++;
        if (entry_word !== 32'h12345678 || digit_count !== 4'd8) begin
            failures++;
            $display("FAIL fill_8 got=%h/%0d exp=12345678/8", entry_word, digit_count);
        end
        digit(4'd9);
        checks++;
        if (entry_word !== 32'h23456789 || digit_count !== 4'd8) begin
            failures++;
            $display("FAIL saturate got=%h/%0d exp=23456789/8", entry_word, digit_count);
        end
    endtask

    task automatic test_commit_handshake();
        press(1'b0, 1'b0, 1'b1);
        digit(4'hB);
        digit(4'hE);
        digit(4'hE);
        digit(4'hF);
        sw_reg_id = 5'd7;
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sw_reg_id = 5'($urandom);
            checks++;
            if (wr_if.wr_valid !== 1'b1 || wr_if.wr_id !== 5'd7 || wr_if.wr_data !== 32'h0000BEEF || busy !== 1'b1) begin
                failures++;
                $display("FAIL commit_hold got=%b/%h/%h/%b exp=1/07/0000beef/1",
                         wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data, busy);
            end
            tick();
        end
        wr_if.wr_ready = 1'b1;
        tick();
        wr_if.wr_ready = 1'b0;
        checks++;
        if (wr_if.wr_valid !== 1'b0 || busy !== 1'b0 || entry_word !== 32'h0 || digit_count !== 4'd0) begin
            failures++;
            $display("FAIL commit_transfer got=%b/%b/%h/%0d exp=0/0/0/0",
                     wr_if.wr_valid, busy, entry_word, digit_count);
        end
        m_word = '0;
        m_count = 0;
        m_pending = 1'b0;
    endtask

    task automatic test_empty_commit_and_coincident();
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_if.wr_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_commit got=%b/%b exp=0/0", wr_if.wr_valid, busy);
        end
        digit(4'h3);
        sw_nibble = 4'h6;
        press(1'b1, 1'b0, 1'b1);
        checks++;
        if (entry_word !== 32'h0 || digit_count !== 4'd0) begin
            failures++;
            $display("FAIL clear_beats_digit got=%h/%0d exp=0/0", entry_word, digit_count);
        end
    endtask

    task automatic test_request_drop_and_reset();
        digit(4'h5);
        digit(4'hA);
        sw_reg_id = 5'd3;
        press(1'b0, 1'b1, 1'b0);
        digit(4'h9);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (entry_word !== 32'h5A || digit_count !== 4'd2 || wr_if.wr_data !== 32'h5A || wr_if.wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL request_drop got=%h/%0d/%h/%b exp=5a/2/5a/1",
                     entry_word, digit_count, wr_if.wr_data, wr_if.wr_valid);
        end
        wr_if.wr_ready = 1'b1;
        tick();
        wr_if.wr_ready = 1'b0;
        checks++;
        if (entry_word !== 32'h0 || wr_if.wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL request_drop_transfer got=%h/%b exp=0/0", entry_word, wr_if.wr_valid);
        end
        m_word = '0;
        m_count = 0;
        m_pending = 1'b0;
        digit(4'hC);
        sw_reg_id = 5'd12;
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_if.wr_valid !== 1'b1 || wr_if.wr_id !== 5'd12) begin
            failures++;
            $display("FAIL second_request got=%b/%h exp=1/0c", wr_if.wr_valid, wr_if.wr_id);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({entry_word, digit_count, busy, wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data} !== 75'd0) begin
            failures++;
            $display("FAIL reset_in_request got=%h/%0d/%b/%b/%h/%h exp=all zero",
                     entry_word, digit_count, busy, wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data);
        end
        reset = 1'b0;
        repeat (3) tick();
        m_word = '0;
        m_count = 0;
        m_pending = 1'b0;
        m_id = '0;
        m_data = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            if (m_pending && $urandom_range(0, 1) == 0) begin
                for (int d = $urandom_range(0, 3); d > 0; d--) tick();
                wr_if.wr_ready = 1'b1;
                tick();
                wr_if.wr_ready = 1'b0;
                m_word = '0;
                m_count = 0;
                m_pending = 1'b0;
            end else begin
                int r = $urandom_range(0, 9);
                sw_nibble = 4'($urandom);
                sw_reg_id = 5'($urandom);
                if (r < 6) press(1'b1, 1'b0, 1'b0);
                else if (r < 8) press(1'b0, 1'b1, 1'b0);
                else press(1'b0, 1'b0, 1'b1);
            end
            checks++;
            if (entry_word !== m_word || digit_count !== 4'(m_count) || busy !== m_pending ||
                wr_if.wr_valid !== m_pending || (m_pending && (wr_if.wr_id !== m_id || wr_if.wr_data !== m_data))) begin
                failures++;
                $display("FAIL random_%0d got=%h/%0d/%b/%h/%h exp=%h/%0d/%b/%h/%h", it,
                         entry_word, digit_count, wr_if.wr_valid, wr_if.wr_id, wr_if.wr_data,
                         m_word, m_count, m_pending, m_id, m_data);
            end
        end
    endtask

    initial begin
        wr_if.wr_ready = 1'b0;
        test_reset();
        test_debounce_timing();
        test_digit_saturation();
        test_commit_handshake();
        test_empty_commit_and_coincident();
        test_request_drop_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
